// File: rtl/adc_cap_pkg.sv
// =====================================================================
// Module   : adc_cap_pkg
// Brief    : Shared state encoding and default sizing for adc_capture
// Revision : 1.0
// =====================================================================
`default_nettype none

package adc_cap_pkg;

    localparam int c_DEF_DATA_W      = 8;
    localparam int c_DEF_ADC_DIV     = 4;
    localparam int c_DEF_LOCK_SETTLE = 1024;
    localparam int c_DEF_FRAME_LEN   = 1024;

    typedef enum logic [2:0] {
        LOCK_WAIT = 3'd0,
        IDLE      = 3'd1,
        ARMED     = 3'd2,
        CAPTURE   = 3'd3,
        DONE      = 3'd4
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/lock_qualifier.sv
// =====================================================================
// Module   : lock_qualifier
// Brief    : Synchronises PLL lock and requires it stable for SETTLE cycles
// Revision : 1.0
// =====================================================================
`default_nettype none

module lock_qualifier #(
    parameter int SETTLE = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int c_CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_settled;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_settled <= 1'b0;
        end else if (!r_sync2) begin
            r_cnt     <= '0;
            r_settled <= 1'b0;
        end else if (!r_settled) begin
            if (r_cnt == c_CNT_W'(SETTLE - 1)) begin
                r_settled <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Gating with the synchronised level drops lock_ok in the cycle the loss is seen.
    assign lock_ok = r_settled & r_sync2;

endmodule

`default_nettype wire

// File: rtl/adc_capture.sv
// =====================================================================
// Module   : adc_capture
// Brief    : ADC front end: sample clock, decimation, edge trigger, framing
// Revision : 1.0
// =====================================================================
`default_nettype none

module adc_capture
    import adc_cap_pkg::*;
#(
    parameter int DATA_W      = c_DEF_DATA_W,
    parameter int ADC_DIV     = c_DEF_ADC_DIV,
    parameter int LOCK_SETTLE = c_DEF_LOCK_SETTLE,
    parameter int FRAME_LEN   = c_DEF_FRAME_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    output logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [7:0]        decim,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              smp_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int c_HALF  = ADC_DIV / 2;
    localparam int c_DIV_W = $clog2(ADC_DIV);
    localparam int c_IDX_W = $clog2(FRAME_LEN);

    logic                w_lock_ok;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                r_adc_clk;
    logic                w_stb;
    logic [DATA_W-1:0]   r_sample;
    logic                r_sample_vld;
    logic [7:0]          r_decim;
    logic [7:0]          r_dec_cnt;
    logic                w_dstb;
    logic [DATA_W-1:0]   r_trig_level;
    logic                r_trig_slope;
    logic [DATA_W-1:0]   r_prev;
    logic                r_prev_vld;
    logic                w_rise;
    logic                w_fall;
    logic                w_trig;
    logic [c_IDX_W-1:0]  r_idx;
    logic                w_arm_ok;
    logic                w_new_smp;
    logic                w_new_last;
    cap_state_t          r_state;
    cap_state_t          w_next;
    logic                w_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_smp_data;
    logic                r_smp_valid;
    logic                r_smp_last;
    logic                r_overflow;

    lock_qualifier #(
        .SETTLE     (LOCK_SETTLE)
    ) u_lock_qualifier (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .lock_ok    (w_lock_ok)
    );

    // ---------------- sample clock divider ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_adc_clk <= 1'b0;
        end else if (!w_lock_ok) begin
            r_div_cnt <= '0;
            r_adc_clk <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == c_DIV_W'(ADC_DIV - 1)) ? '0 : r_div_cnt + 1'b1;
            r_adc_clk <= (r_div_cnt < c_DIV_W'(c_HALF));
        end
    end

    // adc_clk is high while the count is below c_HALF, so this count is its falling edge.
    assign w_stb   = w_lock_ok && (r_div_cnt == c_DIV_W'(c_HALF));
    assign adc_clk = r_adc_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample_vld <= w_stb;
            if (w_stb) begin
                r_sample <= adc_data;
            end
        end
    end

    // ---------------- arm, per-frame configuration ----------------
    assign w_arm_ok = w_lock_ok && arm && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decim      <= '0;
            r_trig_level <= '0;
            r_trig_slope <= 1'b0;
        end else if (w_arm_ok) begin
            r_decim      <= decim;
            r_trig_level <= trig_level;
            r_trig_slope <= trig_slope;
        end
    end

    // ---------------- decimator ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
        end else if (w_arm_ok) begin
            r_dec_cnt <= '0;
        end else if (r_sample_vld) begin
            r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
        end
    end

    assign w_dstb = r_sample_vld && (r_dec_cnt == 8'd0);

    // ---------------- edge trigger ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else if (w_arm_ok) begin
            r_prev_vld <= 1'b0;
        end else if (w_dstb) begin
            r_prev     <= r_sample;
            r_prev_vld <= 1'b1;
        end
    end

    assign w_rise = (r_prev < r_trig_level) && (r_sample >= r_trig_level);
    assign w_fall = (r_prev > r_trig_level) && (r_sample <= r_trig_level);
    assign w_trig = w_dstb && r_prev_vld && (r_trig_slope ? w_fall : w_rise);

    // ---------------- frame sample index ----------------
    assign w_new_smp  = w_lock_ok && (((r_state == ARMED) && w_trig) ||
                                      ((r_state == CAPTURE) && w_dstb));
    assign w_new_last = (r_state == CAPTURE) && (r_idx == c_IDX_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if ((r_state == ARMED) && w_trig) begin
            r_idx <= c_IDX_W'(1);
        end else if ((r_state == CAPTURE) && w_dstb) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOCK_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!w_lock_ok) begin
            w_next = LOCK_WAIT;
        end else begin
            case (r_state)
                LOCK_WAIT: w_next = IDLE;
                IDLE:      if (w_arm_ok) w_next = ARMED;
                ARMED:     if (w_trig) w_next = CAPTURE;
                CAPTURE:   if (w_dstb && w_new_last) w_next = DONE;
                DONE:      if (w_arm_ok) w_next = ARMED;
                default:   w_next = LOCK_WAIT;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ARMED,
            CAPTURE: w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == CAPTURE) && (w_next == DONE);
        end
    end

    // ---------------- output register ----------------
    // A dropped sample still advances r_idx, keeping the frame timebase fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_data  <= '0;
            r_smp_valid <= 1'b0;
            r_smp_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_arm_ok) begin
                r_overflow <= 1'b0;
            end
            if (!w_lock_ok) begin
                r_smp_valid <= 1'b0;
                r_smp_last  <= 1'b0;
            end else if (w_new_smp) begin
                if (r_smp_valid && !smp_ready) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_smp_data  <= r_sample;
                    r_smp_valid <= 1'b1;
                    r_smp_last  <= w_new_last;
                end
            end else if (r_smp_valid && smp_ready) begin
                r_smp_valid <= 1'b0;
                r_smp_last  <= 1'b0;
            end
        end
    end

    assign smp_data  = r_smp_data;
    assign smp_valid = r_smp_valid;
    assign smp_last  = r_smp_last;
    assign busy      = w_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_adc_capture.sv
// =====================================================================
// Module   : tb_adc_capture
// Brief    : Directed self-checking bench for adc_capture
// Revision : 1.0
// =====================================================================
`default_nettype none

module tb_adc_capture;

    localparam int c_DATA_W    = 8;
    localparam int c_ADC_DIV   = 4;
    localparam int c_SETTLE    = 16;
    localparam int c_FRAME_LEN = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         pll_locked;
    logic         adc_clk;
    logic [7:0]   adc_data;
    logic         arm;
    logic [7:0]   trig_level;
    logic         trig_slope;
    logic [7:0]   decim;
    logic [7:0]   smp_data;
    logic         smp_valid;
    logic         smp_ready;
    logic         smp_last;
    logic         busy;
    logic         done;
    logic         overflow;

    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];

    logic [7:0]   ramp_start = 8'd0;
    logic         ramp_dn    = 1'b0;
    int           ramp_seq   = 0;

    adc_capture #(
        .DATA_W      (c_DATA_W),
        .ADC_DIV     (c_ADC_DIV),
        .LOCK_SETTLE (c_SETTLE),
        .FRAME_LEN   (c_FRAME_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .adc_clk     (adc_clk),
        .adc_data    (adc_data),
        .arm         (arm),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .decim       (decim),
        .smp_data    (smp_data),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .smp_last    (smp_last),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC model: a new ramp value follows each adc_clk rising edge.
    initial begin
        int         last_seq;
        logic [7:0] val;
        last_seq = 0;
        val      = 8'd0;
        adc_data = 8'd0;
        forever begin
            @(posedge adc_clk);
            #1;
            if (ramp_seq != last_seq) begin
                val      = ramp_start;
                last_seq = ramp_seq;
            end
            adc_data = val;
            val      = ramp_dn ? val - 8'd1 : val + 8'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_adc_clk"},   adc_clk,   0);
        check({tag, "_smp_data"},  smp_data,  0);
        check({tag, "_smp_valid"}, smp_valid, 0);
        check({tag, "_smp_last"},  smp_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_overflow"},  overflow,  0);
    endtask

    task automatic push_frame(input int first, input int step, input int skip_idx);
        exp_t e;
        for (int k = 0; k < c_FRAME_LEN; k++) begin
            if (k != skip_idx) begin
                e.data = 8'(first + step * k);
                e.last = (k == c_FRAME_LEN - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Restart the ramp so its first value lands on the first ADC period after arm.
    task automatic arm_sync(input logic [7:0] start, input logic dn, input logic [7:0] lvl,
                            input logic slope, input logic [7:0] dec);
        logic prev_adc;
        bit   found;
        @(negedge clk);
        ramp_start = start;
        ramp_dn    = dn;
        ramp_seq++;
        prev_adc   = adc_clk;
        found      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adc_clk && !prev_adc) begin
                found = 1'b1;
                break;
            end
            prev_adc = adc_clk;
        end
        check("arm_sync_adc_clk_running", found, 1);
        trig_level = lvl;
        trig_slope = slope;
        decim      = dec;
        arm        = 1'b1;
        @(negedge clk);
        arm        = 1'b0;
    endtask

    task automatic run_frame(input int budget, input int bp_val, input int stop_after,
                             output int got, output int dones);
        int   bp_cnt;
        bit   bp_done;
        exp_t e;
        bp_cnt  = 0;
        bp_done = 1'b0;
        got     = 0;
        dones   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (bp_cnt > 0) begin
                bp_cnt--;
                if (bp_cnt == 0) smp_ready = 1'b1;
            end else if (!bp_done && bp_val >= 0 && smp_valid && smp_data == 8'(bp_val)) begin
                smp_ready = 1'b0;
                bp_cnt    = 7;
                bp_done   = 1'b1;
            end
            if (smp_valid && smp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                    break;
                end
                e = exp_q.pop_front();
                check("smp_data", smp_data, e.data);
                check("smp_last", smp_last, e.last);
                got++;
                if (exp_q.size() == 0 || got == stop_after) break;
            end
        end
        smp_ready = 1'b1;
        if (stop_after == 0) check("frame_complete_pending", exp_q.size(), 0);
    endtask

    initial begin
        int got;
        int dones;
        int cnt;
        int hi;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        arm        = 1'b0;
        trig_level = 8'd0;
        trig_slope = 1'b0;
        decim      = 8'd0;
        smp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Short lock pulse must not enable the sample clock or leave credit behind.
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (adc_clk) hi++;
        end
        check("short_lock_adc_clk_high", hi, 0);

        pll_locked = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (adc_clk) break;
        end
        check("lock_to_adc_clk_in_18_19", (cnt >= 2 + c_SETTLE) && (cnt <= 3 + c_SETTLE), 1);
        repeat (8) @(negedge clk);
        check("idle_busy", busy, 0);

        // Rising trigger, decim=0; a second arm while ARMED must not retarget the level.
        push_frame(10, 1, -1);
        arm_sync(8'd0, 1'b0, 8'd10, 1'b0, 8'd0);
        check("rise_busy_after_arm", busy, 1);
        repeat (6) @(negedge clk);
        trig_level = 8'd20;
        arm        = 1'b1;
        @(negedge clk);
        arm        = 1'b0;
        trig_level = 8'd10;
        run_frame(300, -1, 0, got, dones);
        check("rise_count", got, 8);
        @(negedge clk);
        if (done) dones++;
        check("rise_done_pulses", dones, 1);
        check("rise_overflow", overflow, 0);
        check("rise_busy_after_frame", busy, 0);

        // Falling trigger with decim=1 on a down ramp 40,39,...
        push_frame(30, -2, -1);
        arm_sync(8'd40, 1'b1, 8'd30, 1'b1, 8'd1);
        run_frame(400, -1, 0, got, dones);
        check("fall_count", got, 8);
        @(negedge clk);
        if (done) dones++;
        check("fall_done_pulses", dones, 1);
        check("fall_overflow", overflow, 0);

        // Backpressure while 12 is held: 13 is dropped, 14 loads as 12 is accepted.
        push_frame(10, 1, 3);
        arm_sync(8'd0, 1'b0, 8'd10, 1'b0, 8'd0);
        run_frame(300, 12, 0, got, dones);
        check("bp_count", got, 7);
        @(negedge clk);
        if (done) dones++;
        check("bp_done_pulses", dones, 1);
        check("bp_overflow_set", overflow, 1);

        // Re-arm from DONE clears overflow; then lose lock mid-frame.
        push_frame(10, 1, -1);
        arm_sync(8'd0, 1'b0, 8'd10, 1'b0, 8'd0);
        check("rearm_overflow_cleared", overflow, 0);
        check("rearm_busy", busy, 1);
        run_frame(300, -1, 4, got, dones);
        check("lossy_count_before_loss", got, 4);
        exp_q.delete();
        pll_locked = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("loss_busy", busy, 0);
        check("loss_smp_valid", smp_valid, 0);
        check("loss_smp_last", smp_last, 0);
        check("loss_adc_clk", adc_clk, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (adc_clk || smp_valid || busy) hi++;
        end
        check("loss_done_pulses", dones, 0);
        check("loss_stays_quiet", hi, 0);

        pll_locked = 1'b1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (adc_clk) hi++;
        end
        check("relock_adc_clk_running", hi > 0, 1);
        check("relock_busy", busy, 0);

        // Asynchronous reset in the middle of a frame.
        push_frame(10, 1, -1);
        arm_sync(8'd0, 1'b0, 8'd10, 1'b0, 8'd0);
        run_frame(300, -1, 2, got, dones);
        check("pre_reset_count", got, 2);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_capture.md
# adc_capture

ADC front-end capture engine clocked by the 100 MHz output of the ADC PLL. It does four things:
- qualifies the PLL lock indication;
- generates the ADC sample clock;
- registers ADC data, decimates it and applies an edge trigger;
- streams one fixed-length frame per arm request to the downstream frame buffer over a valid/ready interface.

## Interface
Parameters:
- DATA_W, 8, ADC sample width.
- ADC_DIV, 4, clk cycles per adc_clk period; even, ≥2.
- LOCK_SETTLE, 1024, clk cycles the PLL lock indication must stay high before capture is enabled.
- FRAME_LEN, 1024, samples per frame; ≥2.

Ports:
- clk  in  1  100 MHz PLL output clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock indication; asynchronous to clk.
- adc_clk  out  1  ADC sample clock.
- adc_data  in  DATA_W  ADC parallel output data.
- arm  in  1  one-cycle request to start a frame.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_slope  in  1  trigger edge: 0 = rising, 1 = falling.
- decim  in  8  keep 1 of every decim+1 ADC samples.
- smp_data  out  DATA_W  output sample.
- smp_valid  out  1  smp_data is valid.
- smp_ready  in  1  downstream accepts the sample.
- smp_last  out  1  marks the final sample of the frame.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  one-cycle pulse when a frame ends.
- overflow  out  1  sticky: at least one sample was dropped.

## Operation
- Lock qualifier:
  - 2-flop synchroniser on pll_locked, then a settle counter.
  - lock_ok goes high once the synchronised lock has been high for LOCK_SETTLE consecutive cycles.
  - A synchronised lock of 0 clears the counter and lock_ok at once.
- adc_clk generation:
  - Divider counter produces a square wave: high for ADC_DIV/2 cycles, then low for ADC_DIV/2 cycles.
  - While !lock_ok, adc_clk is held at 0 and the divider counter is held at 0.
  - stb is high in the cycle whose clock edge takes adc_clk from 1 to 0.
  - adc_data is captured into the sample register at that edge.
- Decimation:
  - A counter runs 0..decim and produces dstb on every sample where the count is 0.
  - The counter is reset by arm.
  - decim is sampled at arm and held for the whole frame.
- Trigger:
  - Compares the previous decimated sample (prev) against the current one (cur).
  - Rising: prev < trig_level and cur ≥ trig_level.
  - Falling: prev > trig_level and cur ≤ trig_level.
  - prev is invalid after arm, so the first decimated sample after arm can never trigger.
  - trig_level and trig_slope are sampled at arm.
- FSM states:
  - LOCK_WAIT: held here while !lock_ok; moves to IDLE when lock_ok.
  - IDLE: arm moves to ARMED.
  - ARMED: a trigger hit moves to CAPTURE; the trigger sample is frame sample 0.
  - CAPTURE: every dstb produces a sample. The sample with index FRAME_LEN−1 carries smp_last and moves the FSM to DONE.
  - DONE: done is pulsed for one cycle. A later arm moves to ARMED.
- Lock loss: in any state, !lock_ok sends the FSM to LOCK_WAIT.
  - smp_valid, smp_last and busy clear in the same cycle.
  - done is not pulsed and the frame is abandoned.
- arm is ignored in LOCK_WAIT, ARMED and CAPTURE.
- arm in IDLE or DONE clears overflow.
- Output stage: a single register.
  - smp_valid stays high until smp_valid && smp_ready.
  - If a new sample arrives while smp_valid && !smp_ready, the new sample is dropped and overflow is set.
  - A dropped sample still counts toward FRAME_LEN, so the frame timebase is preserved; a dropped last sample means smp_last is never seen.
  - If the held sample is accepted in the same cycle a new sample arrives, the new sample is loaded with no drop.
- Reset values:
  - adc_clk = 0, smp_data = 0, smp_valid = 0, smp_last = 0, busy = 0, done = 0, overflow = 0.
  - FSM = LOCK_WAIT.

## Timing
- Lock enable: pll_locked rising to lock_ok takes 2 + LOCK_SETTLE clk cycles.
- Sample latency:
  - adc_data is captured at the stb edge (N).
  - Trigger and decimation are evaluated in cycle N+1.
  - smp_valid rises at edge N+2.
- Output rate: at most one sample per ADC_DIV·(decim+1) cycles. With smp_ready held high, no drops occur.
- done pulses on the edge after the handshake of the FRAME_LEN−1 sample is issued, i.e. with the FSM entering DONE at edge N+2 of the last sample.
- Lock loss: a 1→0 transition on pll_locked takes effect 2 cycles later via the synchroniser.

## Structure
- Package adc_cap_pkg holds:
  - the FSM state enum (LOCK_WAIT, IDLE, ARMED, CAPTURE, DONE);
  - default values for DATA_W, ADC_DIV, LOCK_SETTLE, FRAME_LEN.
- Sub-module lock_qualifier contains the synchroniser and the settle counter. Its parameter is SETTLE; its output is lock_ok.
- The divider, decimator, trigger, FSM and output register stay in adc_capture.

## Test plan
All scenarios use DATA_W=8, ADC_DIV=4, LOCK_SETTLE=16, FRAME_LEN=8.
- Lock timing: pll_locked rises at cycle 0 → adc_clk first goes high no earlier than cycle 18. Drop pll_locked at cycle 5 → no adc_clk and no counter carry-over.
- Rising trigger, decim=0, ramp 0,1,2,…, trig_level=10, smp_ready=1 → 8 samples with values 10..17, smp_last on 17, done one cycle later, overflow=0.
- Falling trigger, decim=1, down-ramp 40,39,…, trig_level=30 → samples taken every 2nd ADC value; the first sample is the first decimated value ≤30, e.g. 30 and then 28.
- Backpressure: smp_ready=0 for 2 ADC periods mid-frame → exactly one sample dropped, overflow=1, frame still ends after 8 counted samples. A following arm clears overflow.
- Lock loss mid-CAPTURE: after sample 3, pll_locked goes to 0 → within 3 cycles FSM is in LOCK_WAIT, smp_valid=0, busy=0, done never pulses, adc_clk=0.
- Arm rules: arm while ARMED → ignored (no restart). Async reset mid-frame → all outputs at their reset values.
